axi_addr_sync_fifo: RTL and testbench



---
 rtl/axi_addr_sync_fifo.sv | 93 +++++++++
 tb/tb_axi_addr_sync_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_sync_fifo.sv
// Single-clock FWFT address FIFO with valid/ready on both sides, almost flags, level and flush.
// Optional sticky overflow/underflow outputs are enabled by defining ADDR_FIFO_ERR_FLAG_EN.
module axi_addr_sync_fifo #(
  parameter int DATA_WIDTH       = 44,
  parameter int DEPTH_WIDTH      = 9,
  parameter int ALMOST_FULL_NUM  = 60,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DEPTH_WIDTH:0]  level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef ADDR_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int                   DEPTH     = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_LVL = DEPTH[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] AF_LVL    = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] AE_LVL    = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] PTR_ONE   = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  if (ALMOST_FULL_NUM > DEPTH || ALMOST_EMPTY_NUM >= DEPTH) begin : g_bad_params
    $error("axi_addr_sync_fifo: almost thresholds out of range for DEPTH=%0d", DEPTH);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_WIDTH:0]  wr_ptr;
  logic [DEPTH_WIDTH:0]  rd_ptr;
  logic                  push;
  logic                  pop;

  // The extra pointer MSB distinguishes full from empty; subtraction wraps mod 2*DEPTH.
  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == DEPTH_LVL);
  assign empty        = (wr_ptr == rd_ptr);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  assign s_ready = !full;
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr[DEPTH_WIDTH-1:0]];

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; m_data is only meaningful while m_valid is high.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= s_data;
  end

`ifdef ADDR_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (s_valid && full)  overflow  <= 1'b1;
      if (m_ready && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_addr_sync_fifo.sv
// Directed bench for axi_addr_sync_fifo (DEPTH=16, AF=12, AE=2): vector table plus corner sequences.
module tb_axi_addr_sync_fifo;

  localparam int DW  = 44;
  localparam int AW  = 4;
  localparam int NV  = 34;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
`ifdef ADDR_FIFO_ERR_FLAG_EN
  logic          overflow;
  logic          underflow;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          fl;
    logic          sv;
    logic          mr;
    logic [DW-1:0] sd;
    logic [AW:0]   lvl;
    logic          mv;
    logic          dchk;
    logic [DW-1:0] md;
    logic          ef;
    logic          ee;
    logic          eaf;
    logic          eae;
    logic          esr;
  } vec_t;

  vec_t vecs [NV];

  axi_addr_sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH_WIDTH(AW),
    .ALMOST_FULL_NUM(12),
    .ALMOST_EMPTY_NUM(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .flush(flush),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .level(level),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`ifdef ADDR_FIFO_ERR_FLAG_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic sv, input logic mr, input logic [DW-1:0] sd);
    flush   = fl;
    s_valid = sv;
    m_ready = mr;
    s_data  = sd;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_almost_empty"}, 64'(almost_empty), 64'd1);
    check({tag, "_almost_full"}, 64'(almost_full), 64'd0);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, DW'(base + i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic vec_t mk(input logic sv, input logic mr, input logic [DW-1:0] sd,
                              input int lvl, input logic [DW-1:0] md);
    vec_t v;
    v.fl   = 1'b0;
    v.sv   = sv;
    v.mr   = mr;
    v.sd   = sd;
    v.lvl  = AW'(0) + (AW+1)'(lvl);
    v.mv   = (lvl != 0);
    v.dchk = (lvl != 0);
    v.md   = md;
    v.ef   = (lvl == 16);
    v.ee   = (lvl == 0);
    v.eaf  = (lvl >= 12);
    v.eae  = (lvl <= 2);
    v.esr  = (lvl != 16);
    return v;
  endfunction

  initial begin
    // Fill 16 decrementing beats with the consumer stalled; the head stays at the first beat.
    for (int i = 0; i < 16; i++) vecs[i] = mk(1'b1, 1'b0, DW'(63 - i), i + 1, DW'(63));
    // A 17th write against a full FIFO must be refused.
    vecs[16] = mk(1'b1, 1'b0, DW'(12'h999), 16, DW'(63));
    // Drain: after each pop the head is the next beat in write order.
    for (int j = 0; j < 16; j++) vecs[17 + j] = mk(1'b0, 1'b1, '0, 15 - j, DW'(63 - (j + 1)));
    // Reading an empty FIFO changes nothing.
    vecs[33] = mk(1'b0, 1'b1, '0, 0, '0);

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    check_reset_state("reset");
`ifdef ADDR_FIFO_ERR_FLAG_EN
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_underflow", 64'(underflow), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // Tests 1 and 2: table-driven fill, refused write, drain.
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].fl, vecs[k].sv, vecs[k].mr, vecs[k].sd);
      tick();
      check($sformatf("v%0d_level", k), 64'(level), 64'(vecs[k].lvl));
      check($sformatf("v%0d_m_valid", k), 64'(m_valid), 64'(vecs[k].mv));
      if (vecs[k].dchk) check($sformatf("v%0d_m_data", k), 64'(m_data), 64'(vecs[k].md));
      check($sformatf("v%0d_full", k), 64'(full), 64'(vecs[k].ef));
      check($sformatf("v%0d_empty", k), 64'(empty), 64'(vecs[k].ee));
      check($sformatf("v%0d_almost_full", k), 64'(almost_full), 64'(vecs[k].eaf));
      check($sformatf("v%0d_almost_empty", k), 64'(almost_empty), 64'(vecs[k].eae));
      check($sformatf("v%0d_s_ready", k), 64'(s_ready), 64'(vecs[k].esr));
`ifdef ADDR_FIFO_ERR_FLAG_EN
      if (k == 16) check("overflow_set", 64'(overflow), 64'd1);
`endif
    end
`ifdef ADDR_FIFO_ERR_FLAG_EN
    check("overflow_sticky", 64'(overflow), 64'd1);
    check("underflow_set", 64'(underflow), 64'd1);
`endif
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    check("flush_empty_level", 64'(level), 64'd0);
`ifdef ADDR_FIFO_ERR_FLAG_EN
    check("flush_clr_overflow", 64'(overflow), 64'd0);
    check("flush_clr_underflow", 64'(underflow), 64'd0);
`endif

    // Test 3: continuous stream from empty; first beat lags one cycle, then one beat per cycle.
    drive(1'b0, 1'b1, 1'b1, DW'(256));
    check("stream_pre_m_valid", 64'(m_valid), 64'd0);
    tick();
    check("stream_first_m_valid", 64'(m_valid), 64'd1);
    check("stream_first_data", 64'(m_data), 64'(256));
    for (int k = 1; k < 100; k++) begin
      drive(1'b0, 1'b1, 1'b1, DW'(256 + k));
      tick();
      check($sformatf("stream%0d_data", k), 64'(m_data), 64'(256 + k));
      check($sformatf("stream%0d_level", k), 64'(level), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("stream_drained", 64'(empty), 64'd1);

    // Test 4: at full, simultaneous push and pop only pops; the retried push lands next cycle.
    push_n(16, 32'h200);
    check("t4_full_level", 64'(level), 64'd16);
    drive(1'b0, 1'b1, 1'b1, DW'(12'h777));
    tick();
    check("t4_pop_only_level", 64'(level), 64'd15);
    check("t4_s_ready", 64'(s_ready), 64'd1);
    check("t4_head", 64'(m_data), 64'(32'h201));
    drive(1'b0, 1'b1, 1'b0, DW'(12'h888));
    tick();
    check("t4_refill_level", 64'(level), 64'd16);
    check("t4_refill_full", 64'(full), 64'd1);
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    check("t4_flush_level", 64'(level), 64'd0);

    // Test 5: flush with a simultaneous write discards everything, then a fresh push falls through.
    push_n(7, 32'h300);
    check("t5_level7", 64'(level), 64'd7);
    drive(1'b1, 1'b1, 1'b0, DW'(12'hBAD));
    tick();
    check("t5_flush_level", 64'(level), 64'd0);
    check("t5_flush_empty", 64'(empty), 64'd1);
    check("t5_flush_m_valid", 64'(m_valid), 64'd0);
    drive(1'b0, 1'b1, 1'b0, DW'(12'hABC));
    tick();
    check("t5_after_m_valid", 64'(m_valid), 64'd1);
    check("t5_after_data", 64'(m_data), 64'(12'hABC));
    check("t5_after_level", 64'(level), 64'd1);
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("t5_drained", 64'(empty), 64'd1);

    // Test 6: asynchronous reset in the middle of a stream at level 5.
    push_n(5, 32'h400);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, DW'(32'h500 + k));
      tick();
      check($sformatf("t6_stream%0d_level", k), 64'(level), 64'd5);
    end
    #1;
    rstn = 1'b0;
    #1;
    check_reset_state("t6_async");
    tick();
    check("t6_held_level", 64'(level), 64'd0);
`ifdef ADDR_FIFO_ERR_FLAG_EN
    check("t6_overflow", 64'(overflow), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, DW'(8'h55));
    tick();
    check("t6_post_level", 64'(level), 64'd1);
    check("t6_post_data", 64'(m_data), 64'(8'h55));
    drive(1'b0, 1'b1, 1'b0, DW'(8'h56));
    tick();
    check("t6_post_level2", 64'(level), 64'd2);
    check("t6_post_head", 64'(m_data), 64'(8'h55));
    drive(1'b0, 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
